// File: rtl/tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tracker_pkg
// Purpose  : Shared types and constants for the paddle target tracker.
//            - state_t    : tracker FSM states
//            - widths     : coordinate, pixel count and signed delta widths
//            - defaults   : active frame geometry
// Revision : 1.0  initial release
// ============================================================================
package tracker_pkg;

    localparam int c_COORD_W   = 10;
    localparam int c_CNT_W     = 19;
    localparam int c_DELTA_W   = 11;

    localparam int c_H_ACT_DEF = 640;
    localparam int c_V_ACT_DEF = 480;

    // Initial extremes of the bounding box: min at the top of the range and
    // max at the bottom, so the first target pixel overwrites both.
    localparam logic [c_COORD_W-1:0] c_COORD_MAX = '1;
    localparam logic [c_COORD_W-1:0] c_COORD_MIN = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage : tracker_pkg
`default_nettype wire

// File: rtl/target_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : target_tracker_if
// Purpose  : Pixel-stream input and per-frame object estimate of the tracker.
// Ports    : pix_en, x_pixel, y_pixel, is_target_color   (stream -> tracker)
//            track_valid, obj_x/y/w/h, obj_dx/dy,
//            pix_count, frame_done                       (tracker -> users)
//            master : pixel source / estimate consumer
//            slave  : tracker
// Revision : 1.0  initial release
// ============================================================================
interface target_tracker_if;
    import tracker_pkg::*;

    logic                        pix_en;
    logic [c_COORD_W-1:0]        x_pixel;
    logic [c_COORD_W-1:0]        y_pixel;
    logic                        is_target_color;

    logic                        track_valid;
    logic [c_COORD_W-1:0]        obj_x;
    logic [c_COORD_W-1:0]        obj_y;
    logic [c_COORD_W-1:0]        obj_w;
    logic [c_COORD_W-1:0]        obj_h;
    logic signed [c_DELTA_W-1:0] obj_dx;
    logic signed [c_DELTA_W-1:0] obj_dy;
    logic [c_CNT_W-1:0]          pix_count;
    logic                        frame_done;

    modport master (
        output pix_en, x_pixel, y_pixel, is_target_color,
        input  track_valid, obj_x, obj_y, obj_w, obj_h,
               obj_dx, obj_dy, pix_count, frame_done
    );

    modport slave (
        input  pix_en, x_pixel, y_pixel, is_target_color,
        output track_valid, obj_x, obj_y, obj_w, obj_h,
               obj_dx, obj_dy, pix_count, frame_done
    );

endinterface : target_tracker_if
`default_nettype wire

// File: rtl/target_bbox_accum.sv
`default_nettype none
// ============================================================================
// Module   : target_bbox_accum
// Purpose  : Bounding-box and hit-count accumulator for one frame.
// Ports    : clk, reset             clock, synchronous active-high reset
//            clear_i                return accumulators to their empty values
//            sample_i               a qualified pixel is present this cycle
//            hit_i                  that pixel matches the target colour
//            x_i, y_i               pixel coordinates
//            min_x_o..max_y_o       current bounding box
//            cnt_o                  target pixels seen (saturating)
//            clear_i and sample_i together restart the frame with that pixel.
// Revision : 1.0  initial release
// ============================================================================
module target_bbox_accum
    import tracker_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 clear_i,
    input  wire logic                 sample_i,
    input  wire logic                 hit_i,
    input  wire logic [c_COORD_W-1:0] x_i,
    input  wire logic [c_COORD_W-1:0] y_i,
    output logic      [c_COORD_W-1:0] min_x_o,
    output logic      [c_COORD_W-1:0] max_x_o,
    output logic      [c_COORD_W-1:0] min_y_o,
    output logic      [c_COORD_W-1:0] max_y_o,
    output logic      [c_CNT_W-1:0]   cnt_o
);

    logic [c_COORD_W-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
    logic [c_COORD_W-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;

    // Starting point for this cycle's update: either the running values or,
    // when clearing, the empty-frame values so a restart pixel still counts.
    logic [c_COORD_W-1:0] w_min_x_b, w_max_x_b, w_min_y_b, w_max_y_b;
    logic [c_CNT_W-1:0]   w_cnt_b;

    always_comb begin
        w_min_x_b = clear_i ? c_COORD_MAX : min_x_q;
        w_max_x_b = clear_i ? c_COORD_MIN : max_x_q;
        w_min_y_b = clear_i ? c_COORD_MAX : min_y_q;
        w_max_y_b = clear_i ? c_COORD_MIN : max_y_q;
        w_cnt_b   = clear_i ? '0          : cnt_q;

        min_x_d = w_min_x_b;
        max_x_d = w_max_x_b;
        min_y_d = w_min_y_b;
        max_y_d = w_max_y_b;
        cnt_d   = w_cnt_b;

        if (sample_i && hit_i) begin
            if (x_i < w_min_x_b) min_x_d = x_i;
            if (x_i > w_max_x_b) max_x_d = x_i;
            if (y_i < w_min_y_b) min_y_d = y_i;
            if (y_i > w_max_y_b) max_y_d = y_i;
            if (w_cnt_b != '1)   cnt_d   = w_cnt_b + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            min_x_q <= c_COORD_MAX;
            max_x_q <= c_COORD_MIN;
            min_y_q <= c_COORD_MAX;
            max_y_q <= c_COORD_MIN;
            cnt_q   <= '0;
        end else begin
            min_x_q <= min_x_d;
            max_x_q <= max_x_d;
            min_y_q <= min_y_d;
            max_y_q <= max_y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign min_x_o = min_x_q;
    assign max_x_o = max_x_q;
    assign min_y_o = min_y_q;
    assign max_y_o = max_y_q;
    assign cnt_o   = cnt_q;

endmodule : target_bbox_accum
`default_nettype wire

// File: rtl/target_tracker.sv
`default_nettype none
// ============================================================================
// Module   : target_tracker
// Purpose  : Once-per-frame paddle estimate from per-pixel target hits.
//            Aligns to pixel (0,0), accumulates a bounding box over the
//            frame, and on the last active pixel commits centre, size,
//            velocity, pixel count and track status with a frame_done pulse.
// Ports    : clk    pixel clock
//            reset  synchronous active-high reset
//            trk    target_tracker_if.slave (pixel stream in, estimate out)
// Revision : 1.0  initial release
// ============================================================================
module target_tracker
    import tracker_pkg::*;
#(
    parameter int H_ACT       = c_H_ACT_DEF,
    parameter int V_ACT       = c_V_ACT_DEF,
    parameter int MIN_COUNT   = 64,
    parameter int LOST_FRAMES = 4
)(
    input  wire logic       clk,
    input  wire logic       reset,
    target_tracker_if.slave trk
);

    localparam logic [c_COORD_W-1:0] c_X_LAST = c_COORD_W'(H_ACT - 1);
    localparam logic [c_COORD_W-1:0] c_Y_LAST = c_COORD_W'(V_ACT - 1);
    localparam logic [3:0]           c_LOST   = 4'(LOST_FRAMES);

    state_t state_q, state_d;
    logic   w_clear, w_sample, w_commit;
    logic   w_is_start, w_is_end;

    logic [c_COORD_W-1:0] w_min_x, w_max_x, w_min_y, w_max_y;
    logic [c_CNT_W-1:0]   w_cnt;

    assign w_is_start = trk.pix_en && (trk.x_pixel == '0) && (trk.y_pixel == '0);
    assign w_is_end   = trk.pix_en && (trk.x_pixel == c_X_LAST)
                                   && (trk.y_pixel == c_Y_LAST);

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        w_clear  = 1'b0;
        w_sample = 1'b0;
        w_commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_is_start) begin
                    w_clear  = 1'b1;
                    w_sample = 1'b1;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                if (trk.pix_en) begin
                    w_sample = 1'b1;
                    // A fresh (0,0) either opens the next frame after a commit
                    // (accumulators already empty) or signals an upstream resync;
                    // both cases restart from this pixel.
                    if (w_is_start)    w_clear = 1'b1;
                    else if (w_is_end) state_d = COMMIT;
                end
            end
            COMMIT: begin
                w_commit = 1'b1;
                w_clear  = 1'b1;
                state_d  = ACCUM;
            end
            default: state_d = IDLE;
        endcase
    end

    target_bbox_accum u_accum (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (w_clear),
        .sample_i (w_sample),
        .hit_i    (trk.is_target_color),
        .x_i      (trk.x_pixel),
        .y_i      (trk.y_pixel),
        .min_x_o  (w_min_x),
        .max_x_o  (w_max_x),
        .min_y_o  (w_min_y),
        .max_y_o  (w_max_y),
        .cnt_o    (w_cnt)
    );

    // ------------------------------------------------------------------
    // Commit datapath
    // ------------------------------------------------------------------
    logic                        track_valid_q;
    logic [c_COORD_W-1:0]        obj_x_q, obj_y_q, obj_w_q, obj_h_q;
    logic signed [c_DELTA_W-1:0] obj_dx_q, obj_dy_q;
    logic [c_CNT_W-1:0]          pix_count_q;
    logic                        frame_done_q;
    logic [3:0]                  lost_cnt_q;

    logic                        w_hit;
    logic [c_COORD_W:0]          w_sum_x, w_sum_y;
    logic [c_COORD_W-1:0]        w_cx, w_cy, w_bw, w_bh;
    logic signed [c_DELTA_W-1:0] w_dx, w_dy;
    logic [3:0]                  w_lost_next;

    assign w_hit   = (w_cnt >= c_CNT_W'(MIN_COUNT));
    assign w_sum_x = {1'b0, w_min_x} + {1'b0, w_max_x};
    assign w_sum_y = {1'b0, w_min_y} + {1'b0, w_max_y};
    assign w_cx    = c_COORD_W'(w_sum_x >> 1);
    assign w_cy    = c_COORD_W'(w_sum_y >> 1);
    assign w_bw    = w_max_x - w_min_x + c_COORD_W'(1);
    assign w_bh    = w_max_y - w_min_y + c_COORD_W'(1);

    // Velocity is only meaningful against a centre from a tracked frame.
    assign w_dx = track_valid_q ? $signed({1'b0, w_cx} - {1'b0, obj_x_q}) : '0;
    assign w_dy = track_valid_q ? $signed({1'b0, w_cy} - {1'b0, obj_y_q}) : '0;

    assign w_lost_next = (lost_cnt_q >= c_LOST) ? c_LOST : lost_cnt_q + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            track_valid_q <= 1'b0;
            obj_x_q       <= '0;
            obj_y_q       <= '0;
            obj_w_q       <= '0;
            obj_h_q       <= '0;
            obj_dx_q      <= '0;
            obj_dy_q      <= '0;
            pix_count_q   <= '0;
            frame_done_q  <= 1'b0;
            lost_cnt_q    <= c_LOST;
        end else begin
            frame_done_q <= w_commit;
            if (w_commit) begin
                pix_count_q <= w_cnt;
                if (w_hit) begin
                    obj_x_q       <= w_cx;
                    obj_y_q       <= w_cy;
                    obj_w_q       <= w_bw;
                    obj_h_q       <= w_bh;
                    obj_dx_q      <= w_dx;
                    obj_dy_q      <= w_dy;
                    track_valid_q <= 1'b1;
                    lost_cnt_q    <= '0;
                end else begin
                    obj_dx_q   <= '0;
                    obj_dy_q   <= '0;
                    lost_cnt_q <= w_lost_next;
                    if (w_lost_next == c_LOST) track_valid_q <= 1'b0;
                end
            end
        end
    end

    assign trk.track_valid = track_valid_q;
    assign trk.obj_x       = obj_x_q;
    assign trk.obj_y       = obj_y_q;
    assign trk.obj_w       = obj_w_q;
    assign trk.obj_h       = obj_h_q;
    assign trk.obj_dx      = obj_dx_q;
    assign trk.obj_dy      = obj_dy_q;
    assign trk.pix_count   = pix_count_q;
    assign trk.frame_done  = frame_done_q;

endmodule : target_tracker
`default_nettype wire
